// File: rtl/fps_regmap_ctrl.sv
// rtl/fps_regmap_ctrl.sv - UART byte-protocol config register map with shadow/active commit
//
// Purpose: decodes write/read command frames from an RX UART byte stream, holds
// NUMREGS 8-bit registers as a shadow/active pair, and answers reads through a TX
// UART handshake. The active copy feeds the analog core and only changes on commit.
//
// Optional feature macro: FPS_REGMAP_CHECKSUM_EN (3-byte write frames cmd,data,chk
// with chk == cmd ^ data). Without it write frames are 2 bytes.
//
// Ports:
//   clk          - UART/regmap clock
//   reset_n      - asynchronous active-low reset
//   rx_data      - byte from RX UART, qualified by rx_valid (one-cycle strobe)
//   tx_data      - response byte, held with tx_valid until tx_ready
//   config_bits  - active registers, reg i = [8*i+:8]
//   commit_pulse - high in the cycle active has just been loaded from shadow
//   err_pulse    - one-cycle pulse the cycle after any protocol error
//   err_count    - saturating protocol error count
module fps_regmap_ctrl #(
    parameter int                     NUMREGS     = 16,
    parameter logic [NUMREGS*8-1:0]   DEFAULTS    = {NUMREGS{8'h00}},
    parameter logic [6:0]             COMMIT_ADDR = 7'h7F,
    parameter int                     TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUMREGS*8-1:0]   config_bits,
    output logic                   commit_pulse,
    output logic                   err_pulse,
    output logic [7:0]             err_count
);

    localparam int         TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0] NR7 = 7'(NUMREGS);

`ifdef FPS_REGMAP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GET_DATA = 2'd1, SEND_RESP = 2'd2, GET_CHK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GET_DATA = 2'd1, SEND_RESP = 2'd2} state_t;
`endif

    state_t               state_q, state_d;
    logic [6:0]           addr_q, addr_d;
    logic [NUMREGS*8-1:0] shadow_q, shadow_d;
    logic [NUMREGS*8-1:0] active_q, active_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 commit_q, commit_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [TW-1:0]        tmo_q, tmo_d;
`ifdef FPS_REGMAP_CHECKSUM_EN
    logic [7:0]           data_q, data_d;
`endif

    logic                 take_cmd;
    logic                 exec_write;
    logic                 err_ev;
    logic [7:0]           wdata;
    int                   ridx;
    int                   widx;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        commit_d   = 1'b0;
        tmo_d      = tmo_q;
        take_cmd   = 1'b0;
        exec_write = 1'b0;
        err_ev     = 1'b0;
        ridx       = int'(rx_data[6:0]);
        widx       = int'(addr_q);
`ifdef FPS_REGMAP_CHECKSUM_EN
        data_d     = data_q;
        wdata      = data_q;
`else
        wdata      = rx_data;
`endif

        case (state_q)
            IDLE: take_cmd = rx_valid;
            GET_DATA: begin
                if (rx_valid) begin
                    tmo_d = '0;
`ifdef FPS_REGMAP_CHECKSUM_EN
                    data_d  = rx_data;
                    state_d = GET_CHK;
`else
                    exec_write = 1'b1;
                    state_d    = IDLE;
`endif
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = '0;
                    err_ev  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`ifdef FPS_REGMAP_CHECKSUM_EN
            GET_CHK: begin
                if (rx_valid) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                    if (rx_data == ({1'b1, addr_q} ^ data_q)) exec_write = 1'b1;
                    else                                      err_ev     = 1'b1;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = '0;
                    err_ev  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`endif
            SEND_RESP: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                    // A byte landing in the handshake cycle starts the next frame.
                    take_cmd   = rx_valid;
                end else if (rx_valid) begin
                    err_ev = 1'b1;   // overrun: no backpressure on RX, byte is lost
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_cmd) begin
            if (rx_data[7]) begin
                addr_d  = rx_data[6:0];
                tmo_d   = '0;
                state_d = GET_DATA;
            end else begin
                state_d    = SEND_RESP;
                tx_valid_d = 1'b1;
                if (rx_data[6:0] < NR7) begin
                    tx_data_d = active_q[ridx*8 +: 8];
                end else if (rx_data[6:0] == COMMIT_ADDR) begin
                    tx_data_d = err_count_q;
                end else begin
                    tx_data_d = 8'hEE;
                    err_ev    = 1'b1;
                end
            end
        end

        if (exec_write) begin
            if (addr_q < NR7) begin
                shadow_d[widx*8 +: 8] = wdata;
            end else if (addr_q == COMMIT_ADDR) begin
                active_d = shadow_q;
                commit_d = 1'b1;
            end else begin
                err_ev = 1'b1;
            end
        end

        err_pulse_d = err_ev;
        err_count_d = (err_ev && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            shadow_q    <= DEFAULTS;
            active_q    <= DEFAULTS;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            commit_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            tmo_q       <= '0;
`ifdef FPS_REGMAP_CHECKSUM_EN
            data_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            commit_q    <= commit_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            tmo_q       <= tmo_d;
`ifdef FPS_REGMAP_CHECKSUM_EN
            data_q      <= data_d;
`endif
        end
    end

    assign config_bits  = active_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign commit_pulse = commit_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;

endmodule
